mux_scan_ctrl: RTL

//  Upstream sequencer for the 4:1 channel mux.
//  - Drives the mux select through channels 0..3 and holds each channel for a programmable dwell.
//  - Samples the mux output once per channel and presents all four samples as one 4-bit word with a 1-cycle valid strobe.
//  - Sits between the control logic (start/cont/stop) and the combinational mux.

---
 rtl/mux_scan_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer for a 4:1 channel mux.
// Walks the select through channels 0..3 and holds each one for DWELL settle
// cycles plus one sample cycle. The four samples are published together as a
// single 4-bit word, with a one-cycle valid strobe. Single and continuous
// sweep modes are supported; stop ends a continuous run only at a sweep
// boundary. All outputs come straight from flops.

module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       stop,
    input  logic       mux_out,
    output logic [1:0] select,
    output logic [3:0] capture,
    output logic       valid,
    output logic       busy
);

    // Reject illegal parameterisations at elaboration time.
    generate
        if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
            $error("mux_scan_ctrl: DWELL must be in 1..255");
        end
        if ((DWELL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
            $error("mux_scan_ctrl: CNT_W too narrow to hold DWELL-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [1:0]       select_r;
    logic [1:0]       select_s;
    // Samples of channels 0..2; channel 3 goes straight into capture.
    logic [2:0]       shadow_r;
    logic [2:0]       shadow_s;
    logic [3:0]       capture_r;
    logic [3:0]       capture_s;
    logic             valid_r;
    logic             valid_s;
    logic             busy_r;
    logic             busy_s;
    logic             cont_r;
    logic             cont_s;
    logic             stop_r;
    logic             stop_s;

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        select_s  = select_r;
        shadow_s  = shadow_r;
        capture_s = capture_r;
        valid_s   = 1'b0;
        busy_s    = busy_r;
        cont_s    = cont_r;
        stop_s    = stop_r;

        // A stop request is remembered for the rest of the run; in IDLE it
        // is ignored because busy is low there.
        if (busy_r && stop) begin
            stop_s = 1'b1;
        end else begin
            stop_s = stop_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_SETTLE;
                    cnt_s    = CNT_ZERO;
                    select_s = 2'd0;
                    busy_s   = 1'b1;
                    cont_s   = cont;
                    stop_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_r == DWELL_M1) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_SAMPLE: begin
                cnt_s = CNT_ZERO;
                case (select_r)
                    2'd0:    shadow_s[0] = mux_out;
                    2'd1:    shadow_s[1] = mux_out;
                    2'd2:    shadow_s[2] = mux_out;
                    default: shadow_s    = shadow_r;
                endcase

                if (select_r != 2'd3) begin
                    select_s = select_r + 2'd1;
                    state_s  = ST_SETTLE;
                end else begin
                    // Sweep end: publish all four samples at once.
                    capture_s = {mux_out, shadow_r};
                    valid_s   = 1'b1;
                    select_s  = 2'd0;
                    stop_s    = 1'b0;
                    if (cont_r && !stop_r && !stop) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_IDLE;
                        busy_s  = 1'b0;
                    end
                end
            end

            default: begin
                state_s  = ST_IDLE;
                cnt_s    = CNT_ZERO;
                select_s = 2'd0;
                busy_s   = 1'b0;
                stop_s   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            select_r  <= 2'd0;
            shadow_r  <= 3'd0;
            capture_r <= 4'd0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            cont_r    <= 1'b0;
            stop_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            select_r  <= select_s;
            shadow_r  <= shadow_s;
            capture_r <= capture_s;
            valid_r   <= valid_s;
            busy_r    <= busy_s;
            cont_r    <= cont_s;
            stop_r    <= stop_s;
        end
    end

    assign select  = select_r;
    assign capture = capture_r;
    assign valid   = valid_r;
    assign busy    = busy_r;

    mux_scan_ctrl_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  (valid_r),
        .busy   (busy_r),
        .select (select_r)
    );

endmodule

// Protocol properties of the sequencer outputs.
module mux_scan_ctrl_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       valid,
    input logic       busy,
    input logic [1:0] select
);

    // Sweeps last at least eight cycles, so the strobe is never doubled.
    a_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
        valid |=> !valid);

    // The select is parked on channel 0 whenever no sweep is running.
    a_idle_select: assert property (@(posedge clk) disable iff (!rst_n)
        !busy |-> (select == 2'd0));

endmodule
